// File: rtl/core_data_port.sv
// Data-side port: steers pipeline loads/stores to core-local RAM or the shared bus.
// Define CORE_DATA_PORT_WRITE_POST_EN to add the posted-write buffer for shared stores.
module core_data_port #(
  parameter int DATA_WIDTH       = 16,
  parameter int ADDR_WIDTH       = 16,
  parameter int LOCAL_SEL_BITS   = 2,
  parameter int LOCAL_ADDR_WIDTH = 11,
  parameter int POST_DEPTH       = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [ADDR_WIDTH-1:0]       pipe_addr_i,
  input  logic [DATA_WIDTH-1:0]       pipe_wdata_i,
  input  logic                        pipe_wren_i,
  input  logic                        pipe_rden_i,
  output logic [DATA_WIDTH-1:0]       pipe_rdata_o,
  output logic                        pipe_stall_o,
  output logic [LOCAL_ADDR_WIDTH-1:0] local_addr_o,
  output logic                        local_wren_o,
  output logic [DATA_WIDTH-1:0]       local_wdata_o,
  input  logic [DATA_WIDTH-1:0]       local_q_i,
  output logic                        shared_request_o,
  input  logic                        shared_ready_i,
  output logic [ADDR_WIDTH-1:0]       shared_addr_o,
  output logic                        shared_wren_o,
  output logic                        shared_rden_o,
  output logic [DATA_WIDTH-1:0]       shared_write_val_o,
  input  logic [DATA_WIDTH-1:0]       shared_read_val_i,
  output logic                        posted_pending_o
);

  if (POST_DEPTH < 2 || (POST_DEPTH & (POST_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("core_data_port: POST_DEPTH must be a power of two >= 2");
  end

  logic is_local;
  logic is_shared;
  logic load_accept;
  logic sel_l_q, sel_l_d;

  assign is_local  = (pipe_addr_i[ADDR_WIDTH-1 -: LOCAL_SEL_BITS] == '0);
  assign is_shared = ~is_local;

  assign local_addr_o  = pipe_addr_i[LOCAL_ADDR_WIDTH-1:0];
  assign local_wren_o  = pipe_wren_i & is_local;
  assign local_wdata_o = pipe_wdata_i;

`ifdef CORE_DATA_PORT_WRITE_POST_EN
  localparam int PTR_W = $clog2(POST_DEPTH);

  logic [ADDR_WIDTH-1:0] buf_addr_q [POST_DEPTH];
  logic [DATA_WIDTH-1:0] buf_data_q [POST_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]        count_q, count_d;
  logic                  pending, full, pop, push;

  assign pending = (count_q != '0);
  assign full    = count_q[PTR_W];
  assign pop     = pending & shared_ready_i;
  // A full buffer still accepts a store when the head drains in the same cycle.
  assign push    = is_shared & pipe_wren_i & (~full | pop);

  assign load_accept      = pipe_rden_i & (is_local | (~pending & shared_ready_i));
  assign pipe_stall_o     = is_shared & ((pipe_rden_i & (pending | ~shared_ready_i)) |
                                         (pipe_wren_i & ~push));
  assign shared_request_o = pending | (is_shared & (pipe_rden_i | (pipe_wren_i & ~push)));
  assign posted_pending_o = pending;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      buf_addr_q[wr_ptr_q] <= pipe_addr_i;
      buf_data_q[wr_ptr_q] <= pipe_wdata_i;
    end
  end

  // Buffered writes always win the bus so loads cannot overtake them.
  always_comb begin
    shared_wren_o      = 1'b0;
    shared_rden_o      = 1'b0;
    shared_addr_o      = '0;
    shared_write_val_o = '0;
    if (shared_ready_i) begin
      if (pending) begin
        shared_wren_o      = 1'b1;
        shared_addr_o      = buf_addr_q[rd_ptr_q];
        shared_write_val_o = buf_data_q[rd_ptr_q];
      end else if (is_shared & pipe_rden_i) begin
        shared_rden_o = 1'b1;
        shared_addr_o = pipe_addr_i;
      end
    end
  end
`else
  assign load_accept      = pipe_rden_i & (is_local | shared_ready_i);
  assign pipe_stall_o     = is_shared & (pipe_rden_i | pipe_wren_i) & ~shared_ready_i;
  assign shared_request_o = is_shared & (pipe_rden_i | pipe_wren_i);
  assign posted_pending_o = 1'b0;

  always_comb begin
    shared_wren_o      = 1'b0;
    shared_rden_o      = 1'b0;
    shared_addr_o      = '0;
    shared_write_val_o = '0;
    if (shared_ready_i & is_shared) begin
      if (pipe_rden_i) begin
        shared_rden_o = 1'b1;
        shared_addr_o = pipe_addr_i;
      end else if (pipe_wren_i) begin
        shared_wren_o      = 1'b1;
        shared_addr_o      = pipe_addr_i;
        shared_write_val_o = pipe_wdata_i;
      end
    end
  end
`endif

  // Remember where the accepted load's data will come from next cycle.
  assign sel_l_d = load_accept ? is_local : sel_l_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sel_l_q <= 1'b1;
    else       sel_l_q <= sel_l_d;
  end

  assign pipe_rdata_o = sel_l_q ? local_q_i : shared_read_val_i;

endmodule

// File: tb/tb_core_data_port.sv
// Directed self-checking bench for core_data_port (both with and without the posted-write buffer).
module tb_core_data_port;
  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] pipe_addr, pipe_wdata, pipe_rdata;
  logic        pipe_wren, pipe_rden, pipe_stall;
  logic [10:0] local_addr;
  logic        local_wren;
  logic [15:0] local_wdata;
  logic [15:0] local_q = 16'h0000;
  logic        shared_request, shared_ready;
  logic [15:0] shared_addr, shared_write_val, shared_read_val;
  logic        shared_wren, shared_rden, posted_pending;
  logic [15:0] ram [0:2047];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  core_data_port dut (
    .clk(clk), .reset(reset),
    .pipe_addr_i(pipe_addr), .pipe_wdata_i(pipe_wdata),
    .pipe_wren_i(pipe_wren), .pipe_rden_i(pipe_rden),
    .pipe_rdata_o(pipe_rdata), .pipe_stall_o(pipe_stall),
    .local_addr_o(local_addr), .local_wren_o(local_wren),
    .local_wdata_o(local_wdata), .local_q_i(local_q),
    .shared_request_o(shared_request), .shared_ready_i(shared_ready),
    .shared_addr_o(shared_addr), .shared_wren_o(shared_wren),
    .shared_rden_o(shared_rden), .shared_write_val_o(shared_write_val),
    .shared_read_val_i(shared_read_val), .posted_pending_o(posted_pending)
  );

  // Core-local synchronous RAM, one-cycle read latency
  always @(posedge clk) begin
    if (local_wren) ram[local_addr] <= local_wdata;
    local_q <= ram[local_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_bus(input string tag, input logic wr, input logic rd,
                           input logic [15:0] a, input logic [15:0] v);
    check({tag, "_wren"}, 32'(shared_wren), 32'(wr));
    check({tag, "_rden"}, 32'(shared_rden), 32'(rd));
    check({tag, "_addr"}, 32'(shared_addr), 32'(a));
    check({tag, "_wval"}, 32'(shared_write_val), 32'(v));
  endtask

  task automatic idle();
    pipe_wren = 1'b0; pipe_rden = 1'b0; pipe_addr = 16'h0000; pipe_wdata = 16'h0000;
  endtask

  task automatic store(input logic [15:0] a, input logic [15:0] d);
    pipe_addr = a; pipe_wdata = d; pipe_wren = 1'b1; pipe_rden = 1'b0;
  endtask

  task automatic load(input logic [15:0] a);
    pipe_addr = a; pipe_wdata = 16'h0000; pipe_wren = 1'b0; pipe_rden = 1'b1;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) ram[i] = 16'h0000;
    ram[0] = 16'h1234;
    idle();
    shared_ready = 1'b0; shared_read_val = 16'h0000; reset = 1'b1;
    repeat (2) @(posedge clk);
    sample();
    check("rst_stall", 32'(pipe_stall), 0);
    check("rst_req", 32'(shared_request), 0);
    check_bus("rst", 1'b0, 1'b0, 16'h0000, 16'h0000);
    check("rst_pending", 32'(posted_pending), 0);
    check("rst_rdata_local", 32'(pipe_rdata), 32'h1234);
    next_cycle();
    reset = 1'b0;

    // Local store then load
    store(16'h0010, 16'hBEEF);
    sample();
    check("loc_st_stall", 32'(pipe_stall), 0);
    check("loc_st_wren", 32'(local_wren), 1);
    check("loc_st_addr", 32'(local_addr), 32'h010);
    check("loc_st_req", 32'(shared_request), 0);
    next_cycle();
    load(16'h0010);
    sample();
    check("loc_ld_stall", 32'(pipe_stall), 0);
    check("loc_ld_wren", 32'(local_wren), 0);
    next_cycle();
    idle();
    sample();
    check("loc_ld_rdata", 32'(pipe_rdata), 32'hBEEF);
    next_cycle();

    // Shared load with grant withheld three cycles
    load(16'h8004);
    for (int i = 0; i < 3; i++) begin
      sample();
      check($sformatf("shld_wait%0d_stall", i), 32'(pipe_stall), 1);
      check($sformatf("shld_wait%0d_req", i), 32'(shared_request), 1);
      check_bus($sformatf("shld_wait%0d", i), 1'b0, 1'b0, 16'h0000, 16'h0000);
      next_cycle();
    end
    shared_ready = 1'b1;
    sample();
    check("shld_grant_stall", 32'(pipe_stall), 0);
    check_bus("shld_grant", 1'b0, 1'b1, 16'h8004, 16'h0000);
    next_cycle();
    idle(); shared_ready = 1'b0; shared_read_val = 16'hA5A5;
    sample();
    check("shld_rdata", 32'(pipe_rdata), 32'hA5A5);
    check("shld_idle_req", 32'(shared_request), 0);
    next_cycle();

    // Granted cycle with nothing to issue
    shared_ready = 1'b1;
    sample();
    check("gnt_idle_req", 32'(shared_request), 0);
    check_bus("gnt_idle", 1'b0, 1'b0, 16'h0000, 16'h0000);
    next_cycle();

    // Async reset returns read select to local
    load(16'h8010);
    sample();
    check("rstsel_acc_stall", 32'(pipe_stall), 0);
    next_cycle();
    idle(); shared_ready = 1'b0; shared_read_val = 16'h5A5A;
    sample();
    check("rstsel_shared", 32'(pipe_rdata), 32'h5A5A);
    reset = 1'b1;
    #1;
    check("rstsel_local", 32'(pipe_rdata), 32'hBEEF);
    next_cycle();
    reset = 1'b0;

`ifdef CORE_DATA_PORT_WRITE_POST_EN
    // Five back-to-back posted stores with grant low
    for (int i = 0; i < 4; i++) begin
      store(16'(16'hC000 + i), 16'(16'h0100 + i));
      sample();
      check($sformatf("post%0d_stall", i), 32'(pipe_stall), 0);
      check($sformatf("post%0d_wren", i), 32'(shared_wren), 0);
      next_cycle();
    end
    store(16'hC004, 16'h0104);
    sample();
    check("post_full_stall", 32'(pipe_stall), 1);
    check("post_full_req", 32'(shared_request), 1);
    check("post_full_pending", 32'(posted_pending), 1);
    check("post_full_wren", 32'(shared_wren), 0);
    next_cycle();
    shared_ready = 1'b1;
    sample();
    check("post_poppush_stall", 32'(pipe_stall), 0);
    check_bus("post_drain0", 1'b1, 1'b0, 16'hC000, 16'h0100);
    next_cycle();
    idle();
    for (int j = 1; j < 5; j++) begin
      sample();
      check_bus($sformatf("post_drain%0d", j), 1'b1, 1'b0, 16'(16'hC000 + j), 16'(16'h0100 + j));
      next_cycle();
    end
    sample();
    check("post_empty_pending", 32'(posted_pending), 0);
    check("post_empty_req", 32'(shared_request), 0);
    check("post_empty_wren", 32'(shared_wren), 0);
    next_cycle();

    // Store then load to the same shared address
    store(16'hC010, 16'h0007);
    sample();
    check("ord_st_stall", 32'(pipe_stall), 0);
    check("ord_st_nobypass", 32'(shared_wren), 0);
    check("ord_st_req", 32'(shared_request), 0);
    next_cycle();
    load(16'hC010);
    sample();
    check("ord_ld_stall", 32'(pipe_stall), 1);
    check_bus("ord_wr", 1'b1, 1'b0, 16'hC010, 16'h0007);
    next_cycle();
    sample();
    check("ord_ld_go", 32'(pipe_stall), 0);
    check_bus("ord_rd", 1'b0, 1'b1, 16'hC010, 16'h0000);
    next_cycle();
    idle(); shared_ready = 1'b0; shared_read_val = 16'h4242;
    sample();
    check("ord_rdata", 32'(pipe_rdata), 32'h4242);
    next_cycle();

    // Full buffer with grant: pop and push together, pointers wrap
    for (int k = 0; k < 4; k++) begin
      store(16'(16'hD000 + k), 16'(16'h0200 + k));
      sample();
      check($sformatf("wrap_fill%0d", k), 32'(pipe_stall), 0);
      next_cycle();
    end
    shared_ready = 1'b1;
    for (int k = 4; k < 10; k++) begin
      store(16'(16'hD000 + k), 16'(16'h0200 + k));
      sample();
      check($sformatf("wrap%0d_stall", k), 32'(pipe_stall), 0);
      check_bus($sformatf("wrap%0d", k), 1'b1, 1'b0, 16'(16'hD000 + k - 4), 16'(16'h0200 + k - 4));
      next_cycle();
    end
    shared_ready = 1'b0;
    store(16'hD00A, 16'h020A);
    sample();
    check("wrap_still_full", 32'(pipe_stall), 1);
    next_cycle();
    idle(); shared_ready = 1'b1;
    for (int k = 6; k < 10; k++) begin
      sample();
      check_bus($sformatf("wrap_drain%0d", k), 1'b1, 1'b0, 16'(16'hD000 + k), 16'(16'h0200 + k));
      next_cycle();
    end
    sample();
    check("wrap_empty", 32'(posted_pending), 0);
    next_cycle();

    // Reset with three posted writes outstanding
    shared_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      store(16'(16'hE000 + k), 16'(16'h0300 + k));
      sample();
      next_cycle();
    end
    idle();
    sample();
    check("prst_before", 32'(posted_pending), 1);
    reset = 1'b1;
    #1;
    check("prst_pending", 32'(posted_pending), 0);
    check("prst_req", 32'(shared_request), 0);
    next_cycle();
    reset = 1'b0; shared_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      sample();
      check($sformatf("prst_after%0d_wren", k), 32'(shared_wren), 0);
      check($sformatf("prst_after%0d_req", k), 32'(shared_request), 0);
      next_cycle();
    end
`else
    // Shared store without buffer stalls until granted
    store(16'h9000, 16'h1111);
    shared_ready = 1'b0;
    sample();
    check("shst_wait_stall", 32'(pipe_stall), 1);
    check("shst_wait_req", 32'(shared_request), 1);
    check_bus("shst_wait", 1'b0, 1'b0, 16'h0000, 16'h0000);
    next_cycle();
    shared_ready = 1'b1;
    sample();
    check("shst_grant_stall", 32'(pipe_stall), 0);
    check("shst_pending", 32'(posted_pending), 0);
    check_bus("shst_grant", 1'b1, 1'b0, 16'h9000, 16'h1111);
    next_cycle();
    idle();
    sample();
    check("shst_done_req", 32'(shared_request), 0);
    check("shst_done_wren", 32'(shared_wren), 0);
    next_cycle();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/core_data_port.md
# core_data_port

Parametrised data-side memory interface for a processor core, sitting between the pipeline's data port and both the core-local synchronous RAM and the shared (global memory / device) bus. It decodes each access as local or shared, generates pipeline stall, returns read data with fixed one-cycle latency, and drives the shared bus only while granted. It generalises width and local-region decode and, optionally, adds a posted-write buffer so shared writes do not stall the pipeline.

## Interface
- DATA_WIDTH, 16, data word width
- ADDR_WIDTH, 16, word address width
- LOCAL_SEL_BITS, 2, number of top address bits; all-zero selects local memory
- LOCAL_ADDR_WIDTH, 11, address bits forwarded to local RAM
- POST_DEPTH, 4, posted-write buffer entries (power of two, ≥2)

- clk  in  1  clock
- reset  in  1  reset; asynchronous, active-high
- pipe_addr  in  ADDR_WIDTH  pipeline data address
- pipe_wdata  in  DATA_WIDTH  store data
- pipe_wren / pipe_rden  in  1  store / load request (never both)
- pipe_rdata  out  DATA_WIDTH  load data, valid cycle after accepted load
- pipe_stall  out  1  hold pipeline this cycle
- local_addr  out  LOCAL_ADDR_WIDTH  local RAM address (pipe_addr low bits)
- local_wren  out  1  local RAM write enable
- local_wdata  out  DATA_WIDTH  local RAM write data
- local_q  in  DATA_WIDTH  local RAM read data (1-cycle synchronous)
- shared_request  out  1  request shared bus
- shared_ready  in  1  grant; bus cycle performed this cycle
- shared_addr  out  ADDR_WIDTH  bus address
- shared_wren / shared_rden  out  1  bus write / read strobe
- shared_write_val  out  DATA_WIDTH  bus write data
- shared_read_val  in  DATA_WIDTH  bus read data, valid cycle after granted read
- posted_pending  out  1  posted-write buffer non-empty (fence support)

## Operation
- Local select: pipe_addr[ADDR_WIDTH-1 -: LOCAL_SEL_BITS] == 0. Local accesses never stall; local_wren = pipe_wren & local.
- Shared outputs: when shared_ready=0 all shared_* outputs driven 0 (no tristate). When granted, exactly one bus op is presented, by priority: (1) head of posted buffer (write, pop), (2) pipeline shared load, (3) pipeline shared store (non-posted path only).
- shared_request = posted_pending | (shared & (pipe_rden | pipe_wren not absorbed by buffer)).
- Shared load: stalls while buffer non-empty or shared_ready=0; accepted in the granted cycle with empty buffer. Loads never bypass posted writes (strict ordering).
- Read return: registered sel_l records local/shared of the accepted load; pipe_rdata = sel_l ? local_q : shared_read_val.
- Posted store: pushed when count < POST_DEPTH; stalls when full. Push and pop in the same cycle both take effect; count unchanged.
- Buffer: circular, read/write pointers log2(POST_DEPTH) bits, wrap modulo depth; count 0..POST_DEPTH.
- Reset mid-operation: buffer contents discarded, pointers/count cleared, in-flight bus access abandoned.

## Timing
- Reset values: pipe_stall 0, shared_request 0, shared_wren/rden 0, shared_addr/write_val 0, posted_pending 0, sel_l 1 (local), pipe_rdata = local_q.
- Load latency: 1 cycle after the non-stalled access cycle, local and shared alike.
- Posted store reaches bus no earlier than the cycle after its push (buffer is registered; no same-cycle bypass).
- pipe_stall and shared_* are combinational from pipe_*, shared_ready and buffer state; no combinational path from shared_read_val to pipe_stall.
- Granted cycle with nothing to issue: strobes 0, shared_request 0.

## Configuration
- CORE_DATA_PORT_WRITE_POST_EN defined: posted-write buffer present as above.
- Undefined: no buffer; shared stores behave like loads (stall until granted, issued directly), posted_pending tied 0, POST_DEPTH ignored.

## Test plan
- Local store 0x0010←0xBEEF then load 0x0010 -> no stall, pipe_rdata 0xBEEF cycle after load.
- Shared load 0x8004 with grant withheld 3 cycles -> stall 3 cycles, shared_rden=1 on grant, pipe_rdata = shared_read_val next cycle; shared_* 0 while ungranted.
- Posted mode: 5 back-to-back stores to 0xC000.. with grant low -> first 4 no stall, 5th stalls; grant high -> bus writes in push order, posted_pending falls after last.
- Store to 0xC000 then immediate load 0xC000, grant high -> load stalls until write issued, then read issued next granted cycle.
- Buffer full, grant high, new store -> pop and push same cycle, count stays 4, pointers wrap correctly over 10 stores.
- Reset asserted with 3 posted writes -> posted_pending 0 immediately, no further bus writes after release.
